// File: rtl/cw_sequencer_if.sv
// Sequencer bus: instruction handshake, decoder control word in, datapath strobes out.
interface cw_sequencer_if #(
   parameter int RETIRE_W = 32
);
   logic [31:0]         instr_in;
   logic                instr_valid;
   logic                instr_ready;
   logic [32:0]         cw_in;
   logic [63:0]         k_in;
   logic [4:0]          status_in;
   logic                stall;
   logic [31:0]         I;
   logic [1:0]          state;
   logic [4:0]          status;
   logic                alu_en;
   logic                alu_bs;
   logic                rf_b_en;
   logic                rf_w;
   logic                ram_en;
   logic                ram_w;
   logic                pc_en;
   logic                pc_is;
   logic [4:0]          alu_fs;
   logic [4:0]          rf_sa;
   logic [4:0]          rf_sb;
   logic [4:0]          rf_da;
   logic [1:0]          pc_fs;
   logic [63:0]         k;
   logic                halted;
   logic [RETIRE_W-1:0] retired;

   // sequencer side
   modport slave (
      input  instr_in, instr_valid, cw_in, k_in, status_in, stall,
      output instr_ready, I, state, status,
             alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is,
             alu_fs, rf_sa, rf_sb, rf_da, pc_fs, k, halted, retired
   );

   // instruction memory / decoder / datapath side
   modport master (
      output instr_in, instr_valid, cw_in, k_in, status_in, stall,
      input  instr_ready, I, state, status,
             alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is,
             alu_fs, rf_sa, rf_sb, rf_da, pc_fs, k, halted, retired
   );
endinterface

// File: rtl/cw_sequencer.sv
// Control-unit sequencer: holds I and the micro-state for the decoders,
// gates the selected control word onto the datapath and counts retirements.
module cw_sequencer #(
   parameter int RETIRE_W = 32
) (
   input  logic          clock,
   input  logic          reset,
   cw_sequencer_if.slave bus
);
   localparam logic [1:0] PH_FETCH = 2'd0;
   localparam logic [1:0] PH_EXEC  = 2'd1;
   localparam logic [1:0] PH_HALT  = 2'd2;

   localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

   logic [1:0]          phase_q, phase_d;
   logic [31:0]         i_q, i_d;
   logic [1:0]          state_q, state_d;
   logic [4:0]          status_q, status_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;

   logic in_exec;   // control word is live this cycle
   logic advance;   // execution step commits at the next edge
   logic accept;    // instruction transfer at the next edge

   assign in_exec         = (phase_q == PH_EXEC) && !reset;
   assign advance         = in_exec && !bus.stall;
   assign bus.instr_ready = (phase_q == PH_FETCH) && !reset;
   assign accept          = bus.instr_valid && bus.instr_ready;

   // Next-state: fetch latches I; each unstalled exec cycle takes next_state
   // from the decoder and retires the instruction when it returns to 00.
   always_comb begin
      phase_d   = phase_q;
      i_d       = i_q;
      state_d   = state_q;
      status_d  = status_q;
      retired_d = retired_q;
      case (phase_q)
         PH_FETCH: begin
            if (accept) begin
               i_d     = bus.instr_in;
               state_d = 2'b00;
               phase_d = (bus.instr_in == 32'h0000_0000) ? PH_HALT : PH_EXEC;
            end
         end
         PH_EXEC: begin
            if (!bus.stall) begin
               state_d = bus.cw_in[1:0];
               if (bus.cw_in[2]) status_d = bus.status_in;
               if (bus.cw_in[1:0] == 2'b00) begin
                  retired_d = retired_q + RET_ONE;
                  phase_d   = PH_FETCH;
               end
            end
         end
         default: ;  // HALT is terminal until reset
      endcase
   end

   // State registers, cleared asynchronously so a reset abandons any micro-sequence.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase_q   <= PH_FETCH;
         i_q       <= '0;
         state_q   <= 2'b00;
         status_q  <= '0;
         retired_q <= '0;
      end else begin
         phase_q   <= phase_d;
         i_q       <= i_d;
         state_q   <= state_d;
         status_q  <= status_d;
         retired_q <= retired_d;
      end
   end

   assign bus.I       = i_q;
   assign bus.state   = state_q;
   assign bus.status  = status_q;
   assign bus.retired = retired_q;
   assign bus.halted  = (phase_q == PH_HALT);

   // Read-side strobes and fields follow the control word for the whole
   // exec cycle so the datapath can settle through a stall.
   assign bus.alu_en  = in_exec & bus.cw_in[32];
   assign bus.alu_bs  = in_exec & bus.cw_in[31];
   assign bus.alu_fs  = in_exec ? bus.cw_in[30:26] : 5'd0;
   assign bus.rf_b_en = in_exec & bus.cw_in[25];
   assign bus.rf_sa   = in_exec ? bus.cw_in[24:20] : 5'd0;
   assign bus.rf_sb   = in_exec ? bus.cw_in[19:15] : 5'd0;
   assign bus.rf_da   = in_exec ? bus.cw_in[14:10] : 5'd0;
   assign bus.ram_en  = in_exec & bus.cw_in[8];
   assign bus.pc_is   = in_exec & bus.cw_in[3];
   assign bus.k       = in_exec ? bus.k_in : 64'd0;

   // Write/load side only fires on a committing cycle; stalled cycles hold the PC.
   assign bus.rf_w    = advance & bus.cw_in[9];
   assign bus.ram_w   = advance & bus.cw_in[7];
   assign bus.pc_en   = advance & bus.cw_in[6];
   assign bus.pc_fs   = advance ? bus.cw_in[5:4] : 2'b00;
endmodule

// File: tb/tb_cw_sequencer.sv
// Scoreboard bench for cw_sequencer: the driver walks instructions as lists of
// micro-steps and queues the expected per-cycle view; a monitor compares on negedge.
module tb_cw_sequencer;
   localparam int RW = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   cw_sequencer_if #(.RETIRE_W(RW)) bus ();
   cw_sequencer #(.RETIRE_W(RW)) dut (.clock(clock), .reset(reset), .bus(bus));

   typedef struct packed {
      logic [31:0]   I;
      logic [1:0]    state;
      logic [4:0]    status;
      logic [RW-1:0] ret;
      logic          halted;
      logic          rdy;
      logic [7:0]    strb;   // alu_en alu_bs rf_b_en rf_w ram_en ram_w pc_en pc_is
      logic [4:0]    alu_fs;
      logic [4:0]    rf_sa;
      logic [4:0]    rf_sb;
      logic [4:0]    rf_da;
      logic [1:0]    pc_fs;
      logic [63:0]   k;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // architectural view of the sequencer as the instruction stream defines it
   logic [31:0]   m_I      = '0;
   logic [1:0]    m_state  = '0;
   logic [4:0]    m_status = '0;
   logic [RW-1:0] m_ret    = '0;

   function automatic void cmp(input string nm, input logic [127:0] a, input logic [127:0] x);
      n_cmp++;
      if (a !== x) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, x);
      end
   endfunction

   function automatic logic [32:0] rcw();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[32:0];
   endfunction

   function automatic logic [63:0] rk();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [4:0] rst5();
      logic [31:0] t;
      t = $urandom();
      return t[4:0];
   endfunction

   function automatic exp_t base_exp();
      exp_t e;
      e        = '0;
      e.I      = m_I;
      e.state  = m_state;
      e.status = m_status;
      e.ret    = m_ret;
      return e;
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e     = base_exp();
      e.rdy = 1'b1;
      return e;
   endfunction

   function automatic exp_t exec_exp(input logic [32:0] cw, input logic [63:0] k, input logic stl);
      exp_t e;
      e        = base_exp();
      e.strb   = {cw[32], cw[31], cw[25], cw[9] & ~stl, cw[8], cw[7] & ~stl, cw[6] & ~stl, cw[3]};
      e.alu_fs = cw[30:26];
      e.rf_sa  = cw[24:20];
      e.rf_sb  = cw[19:15];
      e.rf_da  = cw[14:10];
      e.pc_fs  = stl ? 2'b00 : cw[5:4];
      e.k      = k;
      return e;
   endfunction

   // one clock of stimulus, applied just after the rising edge
   task automatic drive(input logic r, input logic v, input logic [31:0] ins, input logic [32:0] cw,
                        input logic [63:0] k, input logic [4:0] st, input logic stl, input exp_t e);
      @(posedge clock);
      #1;
      reset           = r;
      bus.instr_valid = v;
      bus.instr_in    = ins;
      bus.cw_in       = cw;
      bus.k_in        = k;
      bus.status_in   = st;
      bus.stall       = stl;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'($urandom_range(0, 1)), $urandom(), rcw(), rk(), rst5(), 1'b0, exp_t'(0));
      m_I = '0; m_state = '0; m_status = '0; m_ret = '0;
   endtask

   task automatic fetch(input logic [31:0] ins, input int gaps);
      for (int g = 0; g < gaps; g++)
         drive(1'b0, 1'b0, $urandom(), rcw(), rk(), rst5(), 1'($urandom_range(0, 1)), idle_exp());
      drive(1'b0, 1'b1, ins, rcw(), rk(), rst5(), 1'($urandom_range(0, 1)), idle_exp());
      m_I     = ins;
      m_state = 2'b00;
   endtask

   task automatic exec_step(input logic [32:0] cw, input logic [63:0] k, input logic [4:0] st, input int stalls);
      for (int s = 0; s < stalls; s++)
         drive(1'b0, 1'($urandom_range(0, 1)), $urandom(), cw, k, st, 1'b1, exec_exp(cw, k, 1'b1));
      drive(1'b0, 1'($urandom_range(0, 1)), $urandom(), cw, k, st, 1'b0, exec_exp(cw, k, 1'b0));
      m_state = cw[1:0];
      if (cw[2]) m_status = st;
      if (cw[1:0] == 2'b00) m_ret = m_ret + 1'b1;
   endtask

   task automatic rand_instr();
      logic [31:0] ins;
      logic [32:0] cw;
      int          n;
      ins = $urandom();
      if (ins == 32'h0) ins = 32'h1;
      fetch(ins, $urandom_range(0, 2));
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
         cw      = rcw();
         cw[1:0] = (j == n - 1) ? 2'b00 : 2'($urandom_range(1, 3));
         exec_step(cw, rk(), rst5(), $urandom_range(0, 2));
      end
   endtask

   // monitor: every cycle the DUT presents is checked against the queued view
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("regs", 128'({bus.I, bus.state, bus.status, bus.retired, bus.halted, bus.instr_ready}),
                        128'({e.I, e.state, e.status, e.ret, e.halted, e.rdy}));
            cmp("strobes", 128'({bus.alu_en, bus.alu_bs, bus.rf_b_en, bus.rf_w, bus.ram_en,
                                 bus.ram_w, bus.pc_en, bus.pc_is}), 128'(e.strb));
            cmp("fields", {bus.alu_fs, bus.rf_sa, bus.rf_sb, bus.rf_da, bus.pc_fs, bus.k, 20'h0},
                          {e.alu_fs, e.rf_sa, e.rf_sb, e.rf_da, e.pc_fs, e.k, 20'h0});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [32:0] c1, c2;
      exp_t        e;
      bus.instr_valid = 1'b0;
      bus.instr_in    = '0;
      bus.cw_in       = '0;
      bus.k_in        = '0;
      bus.status_in   = '0;
      bus.stall       = 1'b0;

      do_reset();
      do_reset();

      // single-cycle op right out of reset
      c1 = '0; c1[9] = 1'b1; c1[24:20] = 5'd3;
      fetch(32'h8B02_0020, 1);
      exec_step(c1, 64'h0, 5'd0, 0);

      // two-step MOVK: mask then OR, PC advances on the second step only
      c1 = rcw(); c1[30:26] = 5'd0; c1[5:4] = 2'b00; c1[2] = 1'b0; c1[1:0] = 2'b01;
      c2 = rcw(); c2[30:26] = 5'd4; c2[5:4] = 2'b01; c2[2] = 1'b0; c2[1:0] = 2'b00;
      fetch(32'hF280_0041, 0);
      exec_step(c1, 64'hFFFF_0000_FFFF_FFFF, 5'd0, 0);
      exec_step(c2, 64'h0000_1234_0000_0000, 5'd0, 0);

      // three stalled cycles with writes pending
      c1 = rcw(); c1[9] = 1'b1; c1[6] = 1'b1; c1[24:20] = 5'd17; c1[2] = 1'b0; c1[1:0] = 2'b00;
      fetch(32'h1234_5678, 0);
      exec_step(c1, rk(), 5'd0, 3);

      // status load, then an op that must not disturb it
      c1 = rcw(); c1[2] = 1'b1; c1[1:0] = 2'b00;
      fetch(32'hAAAA_0001, 0);
      exec_step(c1, rk(), 5'b10110, 0);
      c2 = rcw(); c2[2] = 1'b0; c2[1:0] = 2'b00;
      fetch(32'hAAAA_0002, 0);
      exec_step(c2, rk(), 5'b00000, 1);

      // counter wrap: 17 single-cycle retirements from zero
      do_reset();
      for (int i = 0; i < 17; i++) begin
         c1 = rcw(); c1[1:0] = 2'b00;
         fetch(32'h100 + i, 0);
         exec_step(c1, rk(), rst5(), 0);
      end

      // randomized instruction stream
      for (int i = 0; i < 150; i++) rand_instr();

      // reset while in the second micro-state of an instruction
      c1 = rcw(); c1[1:0] = 2'b01;
      fetch(32'hCAFE_0001, 0);
      exec_step(c1, rk(), rst5(), 0);
      do_reset();
      for (int i = 0; i < 20; i++) rand_instr();

      // HALT word: terminal, nothing accepted afterwards
      fetch(32'h0000_0000, 1);
      for (int i = 0; i < 5; i++) begin
         e        = base_exp();
         e.halted = 1'b1;
         drive(1'b0, 1'b1, $urandom(), rcw(), rk(), rst5(), 1'($urandom_range(0, 1)), e);
      end
      do_reset();
      for (int i = 0; i < 5; i++) rand_instr();

      @(negedge clock);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cw_sequencer.md
# cw_sequencer

Control-unit sequencer that sits downstream of the per-opcode instruction-word decoders. It fetches and holds the instruction register (I) and the 2-bit micro-state that the decoders read. It consumes the 33-bit control word selected for the current opcode and drives gated, registered-state-qualified strobes to the datapath (ALU, register file, RAM, PC, status). It is the consumer end of the decoder control-word interface: decoders compute `next_state`, and this block stores it, advances it and decides when an instruction retires.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `instr_in` input 32: instruction word from instruction memory.
- `instr_valid` input 1: `instr_in` valid this cycle.
- `instr_ready` output 1: sequencer accepts an instruction this cycle.
- `cw_in` input 33: control word from the selected decoder.
- `k_in` input 64: constant from the selected decoder, passed through.
- `status_in` input 5: ALU status flags.
- `stall` input 1: datapath/RAM not ready; freezes execution.
- `I` output 32: instruction register, fed back to the decoders.
- `state` output 2: micro-state register, fed back to the decoders.
- `status` output 5: latched status register.
- `alu_en`, `alu_bs`, `rf_b_en`, `rf_w`, `ram_en`, `ram_w`, `pc_en`, `pc_is` output 1 each: gated strobes.
- `alu_fs` output 5, `rf_sa`/`rf_sb`/`rf_da` output 5 each, `pc_fs` output 2, `k` output 64: gated fields.
- `halted` output 1: the HALT word was fetched.
- `retired` output `RETIRE_W`: count of completed instructions.

## Operation
- `cw_in` field map, MSB first:
  - [32] alu_en
  - [31] alu_bs
  - [30:26] alu_fs
  - [25] rf_b_en
  - [24:20] rf_sa
  - [19:15] rf_sb
  - [14:10] rf_da
  - [9] rf_w
  - [8] ram_en
  - [7] ram_w
  - [6] pc_en
  - [5:4] pc_fs
  - [3] pc_is
  - [2] status_ld
  - [1:0] next_state
- Phase FSM with three phases: FETCH, EXEC, HALT.
- FETCH:
  - `instr_ready`=1.
  - On `instr_valid`: I<=`instr_in`, state<=00.
  - Go to HALT if `instr_in`==32'h0000_0000, otherwise go to EXEC.
- EXEC:
  - Strobes and fields are driven combinationally from `cw_in`, and `k`=`k_in`.
  - Each cycle with `stall`=0:
    - state<=`cw_in[1:0]`.
    - If `cw_in[2]`=1, status<=`status_in`.
    - If `cw_in[1:0]`==00, the instruction retires: retired<=retired+1 (wraps modulo 2^RETIRE_W), then go to FETCH.
  - With `stall`=1: state, I, status, phase and retired hold. Write/load strobes (`rf_w`, `ram_w`, `pc_en`, `pc_fs`→00) are forced to 0. Read-side fields (`rf_sa`, `rf_sb`, `alu_fs`, `alu_bs`, `k`) stay driven so the datapath settles.
- HALT: terminal. `halted`=1, `instr_ready`=0, all strobes 0. Only `reset` leaves HALT.
- Outside EXEC, all strobes are 0 and `pc_fs`=00 (PC holds). Field outputs are 0 and `k`=0.
- Multi-cycle instructions (e.g. two-step MOVK: state 00 mask, then state 01 OR) run one EXEC cycle per micro-state, with no FETCH in between.
- A `next_state` value of 10 or 11 is accepted as-is. The sequencer does not interpret it.

## Timing
- Reset values:
  - phase=FETCH.
  - I=0, state=00, status=0, retired=0, `halted`=0.
  - All strobes 0, all fields 0, `k`=0.
  - `instr_ready`=1 one delta after reset deasserts. It is held at 0 while `reset`=1.
- Fetch-to-execute latency: 1 cycle. The instruction accepted at edge n drives strobes in cycle n+1.
- A single-cycle instruction (`next_state`=00) occupies 2 cycles, FETCH and EXEC. Throughput is 1 instruction per 2 cycles with no stalls.
- An N-micro-state instruction takes 1+N cycles plus stall cycles.
- Handshake: a transfer occurs only on an edge with `instr_valid`&&`instr_ready`. `instr_in` is ignored otherwise.
- status_ld and retire in the same cycle are both applied at the same edge.
- `reset` mid-EXEC:
  - Immediate, asynchronous return to reset values.
  - Any partially executed micro-sequence is abandoned.
  - No strobe is asserted while `reset`=1.
- `stall` asserted in FETCH has no effect. FETCH depends only on `instr_valid`.

## Test plan
- Reset then single-cycle op:
  - Stimulus: assert `reset` mid-cycle → all outputs 0 immediately.
  - Release reset, present `instr_in`=32'h8B02_0020 with `cw_in` `next_state`=00 and `rf_w`=1.
  - Required: I latches, `rf_w`=1 for exactly one cycle, retired=1, then `instr_ready`=1.
- Two-state MOVK:
  - Stimulus: cycle 1 `cw_in` has alu_fs=00000, next_state=01; cycle 2 has alu_fs=00100, next_state=00.
  - Required: state sequence 00→01→00, `alu_fs` 0 then 4, `pc_fs`=01 only in cycle 2, retired=1.
- Stall:
  - Stimulus: hold `stall`=1 for 3 cycles in EXEC with `rf_w`=1, `pc_en`=1.
  - Required: both strobes 0 for all 3 cycles, state unchanged, `rf_sa` still driven. They assert on the first unstalled cycle.
- Status load:
  - Stimulus: `cw_in[2]`=1, `status_in`=5'b10110.
  - Required: `status`=10110 after the edge. A later op with `cw_in[2]`=0 and `status_in`=0 leaves `status`=10110.
- Halt and reset mid-op:
  - Stimulus: fetch 32'h0.
  - Required: `halted`=1, `instr_ready`=0 indefinitely.
  - Assert `reset` during a state-01 cycle → state=00, retired unchanged from its reset value 0.
- Counter wrap:
  - Stimulus: with `RETIRE_W`=4, retire 17 single-cycle instructions.
  - Required: retired=1.
